// File: rtl/fp_addsub_seq.sv
// Control FSM for a sequential floating-point add/subtract datapath.
// Optional rounding stage is compiled in with `define FP_ADDSUB_ROUND_EN.
module fp_addsub_seq #(
    parameter int MANT_W    = 23,
    parameter int MAX_SHIFT = 8,
    localparam int CW       = $clog2(MANT_W + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op_sub,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic          a_gt_eq_b,
    input  logic          spl_case,
    input  logic          alu_carry,
    input  logic          eqz,
    input  logic [CW-1:0] lzc,
    input  logic          round_up,
    input  logic          round_carry,
    output logic          load_a,
    output logic          load_b,
    output logic          sel_larger,
    output logic          add_sub,
    output logic          op_sign,
    output logic          flush_exp,
    output logic          norm_en,
    output logic          norm_mode,
    output logic          round_en,
    output logic          load_result,
    output logic          sel_result,
    output logic [CW-1:0] shift_amt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ALIGN,
        S_NORM,
        S_ROUND,
        S_RFIX,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] MAX_SHIFT_C = CW'(MAX_SHIFT);

`ifdef FP_ADDSUB_ROUND_EN
    localparam state_t POST_NORM = S_ROUND;
`else
    localparam state_t POST_NORM = S_OUTPUT;
    logic unused_round;
    assign unused_round = round_up ^ round_carry;
`endif

    state_t        state_q;
    logic [CW-1:0] rem_q;
    logic          op_sub_q;
    logic          spl_q;
    logic          norm_first_q;

    logic [CW-1:0] rem_eff;
    logic [CW-1:0] shift_d;
    logic [CW-1:0] rem_d;
    logic          norm_right;
    logic          norm_flush;
    logic          sign_calc;

    // On the first NORM cycle the shift budget comes straight from the LZC.
    always_comb begin
        rem_eff    = norm_first_q ? lzc : rem_q;
        shift_d    = (rem_eff > MAX_SHIFT_C) ? MAX_SHIFT_C : rem_eff;
        rem_d      = rem_eff - shift_d;
        norm_right = norm_first_q & alu_carry;
        norm_flush = norm_first_q & ~alu_carry & eqz;
        sign_calc  = eqz ? 1'b0 : (a_gt_eq_b ? sign_a : (sign_b ^ op_sub_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            op_sub_q     <= 1'b0;
            spl_q        <= 1'b0;
            norm_first_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_LOAD_A;
                        op_sub_q <= op_sub;
                    end
                end
                S_LOAD_A: state_q <= S_LOAD_B;
                S_LOAD_B: state_q <= S_ALIGN;
                S_ALIGN: begin
                    spl_q        <= spl_case;
                    norm_first_q <= 1'b1;
                    state_q      <= spl_case ? S_OUTPUT : S_NORM;
                end
                S_NORM: begin
                    norm_first_q <= 1'b0;
                    if (norm_right) begin
                        state_q <= POST_NORM;
                    end else if (norm_flush) begin
                        state_q <= S_OUTPUT;
                    end else begin
                        rem_q <= rem_d;
                        if (rem_d == '0) begin
                            state_q <= POST_NORM;
                        end
                    end
                end
`ifdef FP_ADDSUB_ROUND_EN
                S_ROUND:  state_q <= (round_up & round_carry) ? S_RFIX : S_OUTPUT;
                S_RFIX:   state_q <= S_OUTPUT;
`endif
                S_OUTPUT: state_q <= S_DONE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_a      = 1'b0;
        load_b      = 1'b0;
        sel_larger  = 1'b0;
        add_sub     = 1'b0;
        op_sign     = 1'b0;
        flush_exp   = 1'b0;
        norm_en     = 1'b0;
        norm_mode   = 1'b0;
        round_en    = 1'b0;
        load_result = 1'b0;
        sel_result  = 1'b0;
        shift_amt   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                busy   = 1'b1;
                load_a = 1'b1;
            end
            S_LOAD_B: begin
                busy   = 1'b1;
                load_b = 1'b1;
            end
            S_ALIGN: begin
                busy       = 1'b1;
                add_sub    = sign_a ^ sign_b ^ op_sub_q;
                sel_larger = ~a_gt_eq_b;
            end
            S_NORM: begin
                busy    = 1'b1;
                op_sign = sign_calc;
                if (norm_right) begin
                    norm_en = 1'b1;
                end else if (norm_flush) begin
                    flush_exp = 1'b1;
                end else begin
                    norm_en   = 1'b1;
                    norm_mode = 1'b1;
                    shift_amt = shift_d;
                end
            end
`ifdef FP_ADDSUB_ROUND_EN
            S_ROUND: begin
                busy     = 1'b1;
                op_sign  = sign_calc;
                round_en = 1'b1;
            end
            S_RFIX: begin
                // Rounding overflowed the mantissa: renormalize right by one.
                busy    = 1'b1;
                op_sign = sign_calc;
                norm_en = 1'b1;
            end
`endif
            S_OUTPUT: begin
                busy        = 1'b1;
                op_sign     = sign_calc;
                load_result = 1'b1;
                sel_result  = spl_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq (default parameters).
module tb_fp_addsub_seq;

    localparam int CW = 5;
`ifdef FP_ADDSUB_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          op_sub = 1'b0;
    logic          sign_a = 1'b0;
    logic          sign_b = 1'b0;
    logic          a_gt_eq_b = 1'b0;
    logic          spl_case = 1'b0;
    logic          alu_carry = 1'b0;
    logic          eqz = 1'b0;
    logic [CW-1:0] lzc = '0;
    logic          round_up = 1'b0;
    logic          round_carry = 1'b0;
    logic          load_a, load_b, sel_larger, add_sub, op_sign, flush_exp;
    logic          norm_en, norm_mode, round_en, load_result, sel_result;
    logic [CW-1:0] shift_amt;
    logic          busy, done;
    logic [18:0]   all_out;

    int n_checks = 0;
    int n_fail   = 0;

    int   obs_done, obs_la, obs_lb, obs_right, obs_left, obs_flush, obs_round;
    logic obs_add_sub, obs_sel_larger, obs_sign, obs_selres, obs_busy_bad;
    int   obs_shifts[$];

    fp_addsub_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
        .sign_a(sign_a), .sign_b(sign_b), .a_gt_eq_b(a_gt_eq_b), .spl_case(spl_case),
        .alu_carry(alu_carry), .eqz(eqz), .lzc(lzc),
        .round_up(round_up), .round_carry(round_carry),
        .load_a(load_a), .load_b(load_b), .sel_larger(sel_larger), .add_sub(add_sub),
        .op_sign(op_sign), .flush_exp(flush_exp), .norm_en(norm_en), .norm_mode(norm_mode),
        .round_en(round_en), .load_result(load_result), .sel_result(sel_result),
        .shift_amt(shift_amt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign all_out = {load_a, load_b, sel_larger, add_sub, op_sign, flush_exp, norm_en,
                      norm_mode, round_en, load_result, sel_result, shift_amt, busy, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic op, input logic sa, input logic sb, input logic ge,
                              input logic spl, input logic cy, input logic z, input int lz,
                              input logic ru, input logic rc);
        op_sub = op; sign_a = sa; sign_b = sb; a_gt_eq_b = ge; spl_case = spl;
        alu_carry = cy; eqz = z; lzc = CW'(lz); round_up = ru; round_carry = rc;
    endtask

    // Launches one operation and records what the controller did on each cycle.
    task automatic run_op(input string name, input int pulse_cyc);
        obs_done = 0; obs_la = 0; obs_lb = 0; obs_right = 0; obs_left = 0;
        obs_flush = 0; obs_round = 0; obs_add_sub = 0; obs_sel_larger = 0;
        obs_sign = 0; obs_selres = 0; obs_busy_bad = 0;
        obs_shifts.delete();
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            start = (cyc == pulse_cyc);
            if (load_a && obs_la == 0) obs_la = cyc;
            if (load_b && obs_lb == 0) obs_lb = cyc;
            if (add_sub) obs_add_sub = 1'b1;
            if (sel_larger) obs_sel_larger = 1'b1;
            if (norm_en && !norm_mode) obs_right++;
            if (norm_en && norm_mode) begin
                obs_left++;
                obs_shifts.push_back(int'(shift_amt));
            end
            if (flush_exp) obs_flush++;
            if (round_en) obs_round++;
            if (load_result) begin
                obs_sign   = op_sign;
                obs_selres = sel_result;
            end
            if (done) begin
                obs_done = cyc;
                break;
            end
            if (!busy) obs_busy_bad = 1'b1;
            tick();
        end
        start = 1'b0;
        $display("op %s: done_cycle=%0d right=%0d left=%0d flush=%0d round=%0d sign=%0b",
                 name, obs_done, obs_right, obs_left, obs_flush, obs_round, obs_sign);
    endtask

    task automatic test_reset();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%h required=0", all_out);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_after_release: outputs=%h required=0", all_out);
        end
    endtask

    task automatic test_add_carry();
        set_inputs(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        run_op("add_carry", 0);
        n_checks++;
        if (obs_la !== 1 || obs_lb !== 2) begin
            n_fail++;
            $display("FAIL add_load_cycles: load_a@%0d load_b@%0d required 1,2", obs_la, obs_lb);
        end
        n_checks++;
        if (obs_add_sub !== 1'b0 || obs_sel_larger !== 1'b0) begin
            n_fail++;
            $display("FAIL add_align: add_sub=%0b sel_larger=%0b required 0,0", obs_add_sub, obs_sel_larger);
        end
        n_checks++;
        if (obs_right !== 1 || obs_left !== 0) begin
            n_fail++;
            $display("FAIL add_norm: right=%0d left=%0d required 1,0", obs_right, obs_left);
        end
        n_checks++;
        if (obs_done !== 6 + RND || obs_sign !== 1'b0 || obs_busy_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: cycle=%0d sign=%0b busy_gap=%0b required %0d,0,0",
                     obs_done, obs_sign, obs_busy_bad, 6 + RND);
        end
        n_checks++;
        if (obs_round !== RND) begin
            n_fail++;
            $display("FAIL add_round_en: count=%0d required %0d", obs_round, RND);
        end
    endtask

    task automatic test_sub_shift();
        set_inputs(1, 0, 0, 0, 0, 0, 0, 20, 0, 0);
        run_op("sub_lzc20", 0);
        n_checks++;
        if (obs_shifts.size() !== 3) begin
            n_fail++;
            $display("FAIL sub_shift_count: got %0d required 3", obs_shifts.size());
        end else if (obs_shifts[0] !== 8 || obs_shifts[1] !== 8 || obs_shifts[2] !== 4) begin
            n_fail++;
            $display("FAIL sub_shift_seq: got %0d,%0d,%0d required 8,8,4",
                     obs_shifts[0], obs_shifts[1], obs_shifts[2]);
        end
        n_checks++;
        if (obs_add_sub !== 1'b1 || obs_sel_larger !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_align: add_sub=%0b sel_larger=%0b required 1,1", obs_add_sub, obs_sel_larger);
        end
        n_checks++;
        if (obs_sign !== 1'b1 || obs_done !== 8 + RND) begin
            n_fail++;
            $display("FAIL sub_done: sign=%0b cycle=%0d required 1,%0d", obs_sign, obs_done, 8 + RND);
        end
    endtask

    task automatic test_eqz();
        set_inputs(1, 1, 1, 1, 0, 0, 1, 0, 1, 1);
        run_op("eqz", 0);
        n_checks++;
        if (obs_flush !== 1 || obs_round !== 0 || obs_right !== 0 || obs_left !== 0) begin
            n_fail++;
            $display("FAIL eqz_path: flush=%0d round=%0d right=%0d left=%0d required 1,0,0,0",
                     obs_flush, obs_round, obs_right, obs_left);
        end
        n_checks++;
        if (obs_sign !== 1'b0 || obs_done !== 6 || obs_add_sub !== 1'b1) begin
            n_fail++;
            $display("FAIL eqz_done: sign=%0b cycle=%0d add_sub=%0b required 0,6,1",
                     obs_sign, obs_done, obs_add_sub);
        end
    endtask

    task automatic test_special();
        set_inputs(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        run_op("special", 0);
        n_checks++;
        if (obs_done !== 5 || obs_selres !== 1'b1 || obs_right + obs_left + obs_flush !== 0) begin
            n_fail++;
            $display("FAIL special: cycle=%0d sel_result=%0b norm_activity=%0d required 5,1,0",
                     obs_done, obs_selres, obs_right + obs_left + obs_flush);
        end
    endtask

    task automatic test_lzc_zero();
        set_inputs(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        run_op("lzc0", 0);
        n_checks++;
        if (obs_left !== 1 || obs_shifts.size() !== 1 || obs_selres !== 1'b0) begin
            n_fail++;
            $display("FAIL lzc0_norm: left=%0d queued=%0d sel_result=%0b required 1,1,0",
                     obs_left, obs_shifts.size(), obs_selres);
        end else if (obs_shifts[0] !== 0) begin
            n_fail++;
            $display("FAIL lzc0_shift: got %0d required 0", obs_shifts[0]);
        end
        n_checks++;
        if (obs_sign !== 1'b1 || obs_add_sub !== 1'b1 || obs_done !== 6 + RND) begin
            n_fail++;
            $display("FAIL lzc0_done: sign=%0b add_sub=%0b cycle=%0d required 1,1,%0d",
                     obs_sign, obs_add_sub, obs_done, 6 + RND);
        end
    endtask

    task automatic test_round_carry();
        set_inputs(0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        run_op("round_carry", 0);
        n_checks++;
        if (obs_right !== 1 + RND || obs_round !== RND || obs_done !== 6 + 2 * RND) begin
            n_fail++;
            $display("FAIL round_carry: right=%0d round=%0d cycle=%0d required %0d,%0d,%0d",
                     obs_right, obs_round, obs_done, 1 + RND, RND, 6 + 2 * RND);
        end
    endtask

    task automatic test_busy_start();
        set_inputs(1, 0, 0, 0, 0, 0, 0, 20, 0, 0);
        run_op("start_in_norm", 5);
        n_checks++;
        if (obs_done !== 8 + RND) begin
            n_fail++;
            $display("FAIL busy_start_latency: cycle=%0d required %0d", obs_done, 8 + RND);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || load_a !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_queued: done=%0b load_a=%0b required 1,0", done, load_a);
        end
    endtask

    task automatic test_back_to_back();
        set_inputs(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        run_op("from_done", 0);
        n_checks++;
        if (obs_la !== 1 || obs_done !== 5) begin
            n_fail++;
            $display("FAIL back_to_back: load_a@%0d cycle=%0d required 1,5", obs_la, obs_done);
        end
    endtask

    task automatic test_reset_mid();
        set_inputs(1, 0, 0, 0, 0, 0, 0, 20, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (norm_en !== 1'b1 || norm_mode !== 1'b1 || shift_amt !== CW'(8)) begin
            n_fail++;
            $display("FAIL mid_norm: norm_en=%0b mode=%0b shift=%0d required 1,1,8",
                     norm_en, norm_mode, shift_amt);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: outputs=%h required 0", all_out);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_release: outputs=%h required 0", all_out);
        end
        $display("op reset_mid: outputs after release=%h", all_out);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add_carry();
        test_sub_shift();
        test_eqz();
        test_special();
        test_lzc_zero();
        test_round_carry();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
